accel_interrupt_controller: RTL and testbench

//  Collects interrupt requests from NUM_SRC accelerators and arbitrates among them.

---
 rtl/accel_interrupt_controller.sv | 132 +++++++++++++
 tb/tb_accel_interrupt_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_interrupt_controller.sv
// Accelerator interrupt controller.
// Collects per-source requests into a pending set, grants one source at a time, and drives
// the fetch unit's redirect path: a vectoring redirect to the source's handler, then a
// return redirect to the saved PC once decode signals handler return.
// Build option: define AIC_FIXED_PRIORITY_EN for fixed priority (lowest eligible index wins);
// otherwise arbitration is round-robin starting at rr_ptr.
module accel_interrupt_controller #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned VECTOR_SHIFT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         irq_req,
  input  logic [NUM_SRC-1:0]         irq_mask,
  input  logic                       irq_enable,
  input  logic [ADDRESS_BITS-1:0]    vector_base,
  input  logic [ADDRESS_BITS-1:0]    resume_PC,
  input  logic                       resume_valid,
  input  logic                       int_return,
  output logic                       accel_interrupt,
  output logic [ADDRESS_BITS-1:0]    INT_target,
  output logic [NUM_SRC-1:0]         irq_ack,
  output logic [$clog2(NUM_SRC)-1:0] active_id,
  output logic                       in_service
);

  localparam int unsigned IdBits = $clog2(NUM_SRC);

  typedef enum logic [1:0] {StIdle, StFire, StService, StReturn} state_t;

  state_t                  state_q;
  logic [NUM_SRC-1:0]      pending_q;
  logic [ADDRESS_BITS-1:0] epc_q;
  logic [IdBits-1:0]       rr_ptr_q;

  logic [NUM_SRC-1:0]      eligible;
  logic [IdBits-1:0]       winner;
  logic                    found;
  logic                    grant;
  logic [NUM_SRC-1:0]      winner_onehot;
  logic [IdBits-1:0]       rr_next;
  logic [ADDRESS_BITS-1:0] vec_target;
  logic [IdBits-1:0]       idx;

  assign eligible = pending_q & ~irq_mask;

  // Pick the first eligible source, scanning upward from rr_ptr and wrapping to 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = IdBits'((32'(rr_ptr_q) + i) % NUM_SRC);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Grant decode, next round-robin pointer and handler address for the winner.
  always_comb begin
    grant         = (state_q == StIdle) && irq_enable && resume_valid && found;
    winner_onehot = NUM_SRC'(1) << winner;
    rr_next       = (32'(winner) == NUM_SRC - 1) ? '0 : winner + 1'b1;
    // Modulo-2^ADDRESS_BITS add: overflow wraps silently.
    vec_target    = vector_base + (ADDRESS_BITS'(winner) << VECTOR_SHIFT);
  end

  // Pending set: a new request in the same cycle as its grant keeps the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~(grant ? winner_onehot : '0)) | irq_req;
    end
  end

  // Service sequencer; every output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      accel_interrupt <= 1'b0;
      INT_target      <= '0;
      irq_ack         <= '0;
      active_id       <= '0;
      in_service      <= 1'b0;
      epc_q           <= '0;
      rr_ptr_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_q         <= StFire;
            active_id       <= winner;
            epc_q           <= resume_PC;
`ifdef AIC_FIXED_PRIORITY_EN
            rr_ptr_q        <= '0;
`else
            rr_ptr_q        <= rr_next;
`endif
            accel_interrupt <= 1'b1;
            INT_target      <= vec_target;
            irq_ack         <= winner_onehot;
          end
        end
        StFire: begin
          accel_interrupt <= 1'b0;
          irq_ack         <= '0;
          in_service      <= 1'b1;
          state_q         <= StService;
        end
        StService: begin
          // No nesting: new requests only accumulate in pending meanwhile.
          if (int_return) begin
            accel_interrupt <= 1'b1;
            INT_target      <= epc_q;
            state_q         <= StReturn;
          end
        end
        StReturn: begin
          accel_interrupt <= 1'b0;
          in_service      <= 1'b0;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_interrupt_controller.sv
// Directed bench for accel_interrupt_controller (NUM_SRC=4, ADDRESS_BITS=20, VECTOR_SHIFT=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_accel_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  irq_req;
  logic [3:0]  irq_mask;
  logic        irq_enable;
  logic [19:0] vector_base;
  logic [19:0] resume_PC;
  logic        resume_valid;
  logic        int_return;
  logic        accel_interrupt;
  logic [19:0] INT_target;
  logic [3:0]  irq_ack;
  logic [1:0]  active_id;
  logic        in_service;

  int total = 0;
  int bad   = 0;

  accel_interrupt_controller dut (
    .clock           (clock),
    .reset           (reset),
    .irq_req         (irq_req),
    .irq_mask        (irq_mask),
    .irq_enable      (irq_enable),
    .vector_base     (vector_base),
    .resume_PC       (resume_PC),
    .resume_valid    (resume_valid),
    .int_return      (int_return),
    .accel_interrupt (accel_interrupt),
    .INT_target      (INT_target),
    .irq_ack         (irq_ack),
    .active_id       (active_id),
    .in_service      (in_service)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    irq_req    = 4'b0;
    int_return = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    irq_req      = 4'hF;
    irq_mask     = 4'b0;
    irq_enable   = 1'b1;
    vector_base  = 20'h01000;
    resume_PC    = 20'h00240;
    resume_valid = 1'b1;
    int_return   = 1'b0;

    // 1 Reset held two edges with all requests high.
    step();
    step();
    chk("rst_accel", accel_interrupt, 0);
    chk("rst_target", INT_target, 0);
    chk("rst_ack", irq_ack, 0);
    chk("rst_id", active_id, 0);
    chk("rst_insvc", in_service, 0);
    reset = 1'b0;
    step();
    chk("rel_nogrant", accel_interrupt, 0);
    irq_req = 4'b0;
    step();
    chk("rel_grant", accel_interrupt, 1);
    chk("rel_ack", irq_ack, 4'b0001);

    // 2 Single request from source 2, plus int_return ignored in IDLE.
    do_reset();
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    chk("ret_idle_ignored", accel_interrupt, 0);
    irq_req = 4'b0100;
    step();
    irq_req = 4'b0;
    step();
    resume_PC = 20'h3FFF0;
    chk("single_accel", accel_interrupt, 1);
    chk("single_target", INT_target, 20'h01020);
    chk("single_ack", irq_ack, 4'b0100);
    chk("single_id", active_id, 2);
    step();
    chk("single_fire_1cyc", accel_interrupt, 0);
    chk("single_ack_1cyc", irq_ack, 0);
    chk("single_insvc", in_service, 1);
    step();
    chk("single_wait", accel_interrupt, 0);
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    chk("single_ret_accel", accel_interrupt, 1);
    chk("single_ret_target", INT_target, 20'h00240);
    step();
    chk("single_ret_1cyc", accel_interrupt, 0);
    chk("single_insvc_drop", in_service, 0);
    resume_PC = 20'h00240;

    // 3 Arbitration between sources 1 and 3, then pointer wrap back to 1.
    do_reset();
    irq_req = 4'b1010;
    step();
    irq_req = 4'b0;
    step();
    chk("arb_first_id", active_id, 1);
    chk("arb_first_target", INT_target, 20'h01010);
    step();
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    chk("arb_first_ret", INT_target, 20'h00240);
    step();
    chk("arb_idle_gap", accel_interrupt, 0);
    step();
    chk("arb_second_accel", accel_interrupt, 1);
    chk("arb_second_id", active_id, 3);
    chk("arb_second_ack", irq_ack, 4'b1000);
    step();
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    step();
    irq_req = 4'b1010;
    step();
    irq_req = 4'b0;
    step();
    chk("arb_wrap_id", active_id, 1);
    chk("arb_wrap_accel", accel_interrupt, 1);

    // 4 Masking and global enable.
    do_reset();
    irq_mask = 4'b0001;
    irq_req  = 4'b0001;
    step();
    irq_req = 4'b0;
    step();
    step();
    chk("mask_blocks", accel_interrupt, 0);
    irq_mask = 4'b0;
    step();
    chk("unmask_grant", accel_interrupt, 1);
    chk("unmask_id", active_id, 0);
    step();
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    step();
    irq_enable = 1'b0;
    irq_req    = 4'b0100;
    step();
    irq_req = 4'b0;
    step();
    step();
    chk("enable_blocks", accel_interrupt, 0);
    irq_enable = 1'b1;
    step();
    chk("enable_pending_kept", accel_interrupt, 1);
    chk("enable_id", active_id, 2);
    step();
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    step();

    // 5 No nesting; the follow-up vector also wraps past the top of the address space.
    do_reset();
    irq_req = 4'b0001;
    step();
    irq_req = 4'b0;
    step();
    step();
    irq_req = 4'b1000;
    step();
    irq_req     = 4'b0;
    vector_base = 20'hFFFF0;
    step();
    chk("nest_blocked", accel_interrupt, 0);
    chk("nest_insvc", in_service, 1);
    chk("nest_id_held", active_id, 0);
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    chk("nest_ret_target", INT_target, 20'h00240);
    step();
    chk("nest_idle_gap", accel_interrupt, 0);
    step();
    chk("nest_fire", accel_interrupt, 1);
    chk("nest_fire_id", active_id, 3);
    chk("nest_wrap_target", INT_target, 20'h00020);
    vector_base = 20'h01000;

    // 6 Reset while in service: no return redirect, pending discarded.
    do_reset();
    irq_req = 4'b0010;
    step();
    irq_req = 4'b0;
    step();
    step();
    chk("rsvc_insvc", in_service, 1);
    irq_req = 4'b0100;
    step();
    irq_req = 4'b0;
    reset   = 1'b1;
    step();
    chk("rsvc_insvc_clr", in_service, 0);
    chk("rsvc_accel", accel_interrupt, 0);
    reset      = 1'b0;
    int_return = 1'b1;
    step();
    int_return = 1'b0;
    chk("rsvc_no_return", accel_interrupt, 0);
    step();
    step();
    chk("rsvc_pending_gone", accel_interrupt, 0);
    chk("rsvc_ack_none", irq_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
